// File: rtl/cla_pipe_add16_if.sv
// Operand/result handshake bundle for cla_pipe_add16.
// The master side drives operands and out_ready; the slave side is the adder.
interface cla_pipe_add16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Ci;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Co;
    logic        OV;
    logic        PG;
    logic        GG;

    modport master (
        output in_valid, A, B, Ci, out_ready,
        input  in_ready, out_valid, S, Co, OV, PG, GG
    );

    modport slave (
        input  in_valid, A, B, Ci, out_ready,
        output in_ready, out_valid, S, Co, OV, PG, GG
    );
endinterface

// File: rtl/cla_pipe_add16.sv
// Two-stage pipelined 16-bit carry-lookahead adder (bit P/G stage, group lookahead stage).
// Define CLA_PIPE_SAT_EN to saturate S on signed overflow instead of wrapping.
module cla_pipe_add16 #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input logic              clk,
    input logic              rst_n,
    cla_pipe_add16_if.slave  bus
);
    localparam int NGRP = WIDTH / GROUP;

    logic [WIDTH-1:0] g_p1, p_p1;
    logic             ci_p1;
    logic             vld_p1, vld_p2;
    logic             rst_hold;
    logic [WIDTH-1:0] s_p2;
    logic             co_p2, ov_p2, pg_p2, gg_p2;

    logic             stage2_free, adv_p1, in_fire;
    logic [NGRP-1:0]  grp_pg, grp_gg, grp_cin;
    logic [WIDTH-1:0] carry_c, sum_c, s_c;
    logic             co_c, ov_c, pg_c, gg_c;

    function automatic logic lookahead_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic [3:0] lookahead_carry(input logic [3:0] g, input logic [3:0] p,
                                                   input logic cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

`ifdef CLA_PIPE_SAT_EN
    // Overflow only happens when both operand signs agree, so G[15] alone gives the sign.
    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] sum, input logic ov,
                                                 input logic neg);
        if (!ov)
            return sum;
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    // in_ready is held low for one cycle after reset so nothing enters a just-cleared pipe.
    assign stage2_free  = !vld_p2 || bus.out_ready;
    assign adv_p1       = vld_p1 && stage2_free;
    assign bus.in_ready = !rst_hold && (!vld_p1 || stage2_free);
    assign in_fire      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_hold <= 1'b1;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            rst_hold <= 1'b0;
            if (in_fire)
                vld_p1 <= 1'b1;
            else if (adv_p1)
                vld_p1 <= 1'b0;
            if (adv_p1)
                vld_p2 <= 1'b1;
            else if (bus.out_ready)
                vld_p2 <= 1'b0;
        end
    end

    // ---- stage 1: bit generate/propagate ----
    always_ff @(posedge clk) begin
        if (in_fire) begin
            g_p1  <= bus.A & bus.B;
            p_p1  <= bus.A ^ bus.B;
            ci_p1 <= bus.Ci;
        end
    end

    always_comb begin
        grp_pg  = '0;
        grp_gg  = '0;
        grp_cin = '0;
        carry_c = '0;
        for (int k = 0; k < NGRP; k++) begin
            grp_pg[k] = &p_p1[k*GROUP +: GROUP];
            grp_gg[k] = lookahead_gen(g_p1[k*GROUP +: GROUP], p_p1[k*GROUP +: GROUP]);
        end
        grp_cin = lookahead_carry(grp_gg, grp_pg, ci_p1);
        co_c    = lookahead_gen(grp_gg, grp_pg) | (&grp_pg & ci_p1);
        for (int k = 0; k < NGRP; k++)
            carry_c[k*GROUP +: GROUP] = lookahead_carry(g_p1[k*GROUP +: GROUP],
                                                        p_p1[k*GROUP +: GROUP], grp_cin[k]);
        sum_c = p_p1 ^ carry_c;
        ov_c  = carry_c[WIDTH-1] ^ co_c;
        pg_c  = &grp_pg;
        gg_c  = lookahead_gen(grp_gg, grp_pg);
`ifdef CLA_PIPE_SAT_EN
        s_c   = sat_sum(sum_c, ov_c, g_p1[WIDTH-1]);
`else
        s_c   = sum_c;
`endif
    end

    // ---- stage 2: result register (cleared so outputs read zero around reset) ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_p2  <= '0;
            co_p2 <= 1'b0;
            ov_p2 <= 1'b0;
            pg_p2 <= 1'b0;
            gg_p2 <= 1'b0;
        end else if (adv_p1) begin
            s_p2  <= s_c;
            co_p2 <= co_c;
            ov_p2 <= ov_c;
            pg_p2 <= pg_c;
            gg_p2 <= gg_c;
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.S         = s_p2;
    assign bus.Co        = co_p2;
    assign bus.OV        = ov_p2;
    assign bus.PG        = pg_p2;
    assign bus.GG        = gg_p2;
endmodule

// File: tb/tb_cla_pipe_add16.sv
// Bench for cla_pipe_add16: directed cases, random streams and backpressure,
// checked against an arithmetic reference model through a result queue.
module tb_cla_pipe_add16;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   in_cnt = 0;
    int   out_cnt = 0;
    logic [19:0] exp_q[$];
    logic [19:0] saved;
    int   in0, out0;

    cla_pipe_add16_if bus ();

    cla_pipe_add16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected {S, Co, OV, PG, GG} from plain integer arithmetic.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci);
        logic [16:0] full, nocin;
        logic [15:0] s;
        logic        ov, pg, gg;
        full  = {1'b0, a} + {1'b0, b} + {16'b0, ci};
        nocin = {1'b0, a} + {1'b0, b};
        s     = full[15:0];
        ov    = (a[15] == b[15]) && (s[15] != a[15]);
        pg    = ((a ^ b) == 16'hFFFF);
        gg    = nocin[16];
`ifdef CLA_PIPE_SAT_EN
        if (ov)
            s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {s, full[16], ov, pg, gg};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic ordy);
        bus.in_valid  = v;
        bus.A         = a;
        bus.B         = b;
        bus.Ci        = ci;
        bus.out_ready = ordy;
    endtask

    // One clock: scoreboard transfers at mid-cycle, then step to just after the edge.
    task automatic tick();
        logic [19:0] o, e;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            out_cnt++;
            o = {bus.S, bus.Co, bus.OV, bus.PG, bus.GG};
            chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result", 32'(o), 32'(e));
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            in_cnt++;
            exp_q.push_back(model(bus.A, bus.B, bus.Ci));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_directed(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                 input logic [19:0] exp);
        drive(1'b1, a, b, ci, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("latency_1_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("latency_2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("directed_result", 32'({bus.S, bus.Co, bus.OV, bus.PG, bus.GG}), 32'(exp));
        tick();
        chk("single_pulse_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_Co", 32'(bus.Co), 32'd0);
        chk("rst_OV", 32'(bus.OV), 32'd0);
        chk("rst_PG", 32'(bus.PG), 32'd0);
        chk("rst_GG", 32'(bus.GG), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        chk("post_rst_in_ready_high", 32'(bus.in_ready), 32'd1);

        send_directed(16'h1234, 16'h4321, 1'b0, {16'h5555, 1'b0, 1'b0, 1'b0, 1'b0});
        send_directed(16'hFFFF, 16'h0000, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
`ifdef CLA_PIPE_SAT_EN
        send_directed(16'h7FFF, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0});
`else
        send_directed(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
`endif
        send_directed(16'h8000, 16'h8000, 1'b1, model(16'h8000, 16'h8000, 1'b1));

        // Back-to-back stream of 8 random vectors.
        in0 = in_cnt;
        out0 = out_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("stream_out_valid", 32'(bus.out_valid), 32'(i >= 2));
            if (i < 8)
                drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b1);
            else
                bus.in_valid = 1'b0;
            tick();
        end
        chk("stream_inputs", 32'(in_cnt - in0), 32'd8);
        chk("stream_outputs", 32'(out_cnt - out0), 32'd8);

        // Backpressure: two accepted, third stalls until out_ready rises.
        in0 = in_cnt;
        out0 = out_cnt;
        drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b0);
        tick();
        drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b0);
        tick();
        drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b0);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        saved = {bus.S, bus.Co, bus.OV, bus.PG, bus.GG};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_result", 32'({bus.S, bus.Co, bus.OV, bus.PG, bus.GG}), 32'(saved));
        end
        chk("bp_accepted_two", 32'(in_cnt - in0), 32'd2);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++)
            tick();
        chk("bp_inputs", 32'(in_cnt - in0), 32'd3);
        chk("bp_outputs", 32'(out_cnt - out0), 32'd3);

        // Reset with both stages full discards everything.
        drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b0);
        tick();
        drive(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b0);
        tick();
        bus.in_valid = 1'b0;
        chk("full_before_reset", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("after_mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("after_mid_rst_no_stale", 32'(bus.out_valid), 32'd0);
        tick();
        chk("after_mid_rst_no_stale_2", 32'(bus.out_valid), 32'd0);

        // Random traffic with random backpressure; operands held while stalled.
        in0 = in_cnt;
        out0 = out_cnt;
        for (int i = 0; i < 300; i++) begin
            if (!(bus.in_valid && !bus.in_ready))
                drive(1'($urandom()), 16'($urandom()), 16'($urandom()), 1'($urandom()),
                      1'($urandom()));
            else
                bus.out_ready = 1'($urandom());
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            tick();
        chk("random_drained", 32'(exp_q.size()), 32'd0);
        chk("random_in_eq_out", 32'(out_cnt - out0), 32'(in_cnt - in0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_pipe_add16.md
Name: cla_pipe_add16

Overview:
- Two-stage pipelined 16-bit carry-lookahead adder built around the existing 4-bit lookahead unit.
- Stage 1 is the upstream bit generate/propagate stage that feeds four 4-bit lookahead groups.
- Stage 2 forms the second-level group carries from the group PG/GG terms and produces sum, carry-out and overflow.
- Valid/ready handshake on input and output, with full backpressure.

Parameters:
- WIDTH, 16, operand width; fixed at 16 (four groups of 4 bits); any other value is unsupported.
- GROUP, 4, bits per lookahead group; fixed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands this cycle
- A  input  16  operand A
- B  input  16  operand B
- Ci  input  1  carry-in for this transaction
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- S  output  16  sum
- Co  output  1  carry-out of bit 15
- OV  output  1  signed overflow (carry into bit 15 XOR carry out of bit 15)
- PG  output  1  block propagate (all 16 P bits set)
- GG  output  1  block generate

Behaviour:
- Reset: rst_n low at a rising edge clears s1_valid and s2_valid.
  - Outputs while in reset and in the cycle after: out_valid=0, S=0, Co=0, OV=0, PG=0, GG=0, in_ready=0.
  - After reset: in_ready=1.
- Input transfer occurs when in_valid and in_ready are both 1 at a rising edge. Output transfer occurs when out_valid and out_ready are both 1.
- Stage 1 (on input transfer) registers:
  - G[i]=A[i]&B[i] and P[i]=A[i]^B[i] for i=0..15;
  - Ci;
  - s1_valid<=1.
- Stage 2 logic from the stage-1 registers:
  - Per group k: group PG_k and GG_k plus the in-group carries, using the 4-bit lookahead equations.
  - Group carries: C4=GG0|PG0&Ci; C8=GG1|PG1&C4; C12=GG2|PG2&C8; Co=GG3|PG3&C12, all expanded as two-level lookahead with no ripple between groups.
  - S[i]=P[i]^c[i]; c[0]=Ci.
  - OV=c[15]^Co.
  - PG=&PG_k; GG = lookahead over GG_k/PG_k, with Ci excluded.
- Stage 2 registers S, Co, OV, PG, GG and sets s2_valid when stage 1 advances.
- Latency: exactly 2 cycles from input transfer to out_valid with out_ready held at 1. Throughput: 1 transaction per cycle.
- Advance rules:
  - stage2_free = !s2_valid | out_ready.
  - Stage 1 advances into stage 2 when s1_valid & stage2_free.
  - in_ready = !s1_valid | (s1_valid & stage2_free). This is combinational from out_ready; no combinational path from in_valid.
- Backpressure: with out_ready=0 and both stages full, in_ready=0. S/Co/OV/PG/GG/out_valid hold stable until accepted. No data is dropped or duplicated.
- Simultaneous events: an output transfer and a stage-1 advance in the same cycle is legal. The new result replaces the old one with out_valid staying 1.
- Bubble: if stage 1 is empty and stage 2 transfers, s2_valid<=0. Data outputs may hold stale values when out_valid=0.
- Reset mid-operation discards both stages. No partial result is emitted.
- Arithmetic is modulo 2^16. Co and OV are reported independently; both may be 1.

Optional Feature:
- Macro CLA_PIPE_SAT_EN.
- When defined, S is saturated on signed overflow:
  - OV=1 with A[15]=B[15]=0 gives S=16'h7FFF;
  - OV=1 with A[15]=B[15]=1 gives S=16'h8000.
  - Co, OV, PG and GG are unaffected.
  - Saturation is applied in stage 2; latency is unchanged.
- When undefined, S is the wrapped sum and the saturation logic is absent.

Test Plan:
- Reset then A=16'h1234, B=16'h4321, Ci=0, out_ready=1 -> after 2 cycles S=16'h5555, Co=0, OV=0, PG=0, GG=0, out_valid=1 for one cycle.
- A=16'hFFFF, B=16'h0000, Ci=1 -> S=16'h0000, Co=1, PG=1, GG=0, OV=0.
- A=16'h7FFF, B=16'h0001, Ci=0 -> OV=1, Co=0. S=16'h8000, or 16'h7FFF with CLA_PIPE_SAT_EN.
- Back-to-back stream of 8 random vectors with out_ready=1 -> 8 consecutive results, in order, matching the A+B+Ci reference model.
- Issue 3 transfers with out_ready=0 -> in_ready drops after 2 accepted; outputs stable. Raise out_ready -> results 1 and 2 emerge in order. The third transfer is accepted only after in_ready returns to 1.
- Assert rst_n=0 with both stages full -> next cycle out_valid=0, in_ready=0. The cycle after, in_ready=1 and no stale result appears.
